// File: rtl/backward_maccum_arbiter.sv
// Round-robin arbiter sharing one backward multiply-accumulate unit among NR requesters.
// Grants are tagged into a small FIFO so results come back to the requester that issued them.
module backward_maccum_arbiter #(
    parameter int NR    = 3,
    parameter int NN    = 7,
    parameter int NC    = 11,
    parameter int WV    = 5,
    parameter int DEPTH = 4,
    localparam int WA   = $clog2(NN) + WV,
    localparam int WT   = $clog2(NR)
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [NR-1:0]            iValid_AM_Req,
    output logic [NR-1:0]            oReady_AM_Req,
    input  logic [NR*NC*NN*WV-1:0]   iData_AM_Weight,
    input  logic [NR*NN*WV-1:0]      iData_AM_Delta0,
    output logic                     oValid_BM_Weight,
    input  logic                     iReady_BM_Weight,
    output logic [NC*NN*WV-1:0]      oData_BM_Weight,
    output logic                     oValid_BM_Delta0,
    input  logic                     iReady_BM_Delta0,
    output logic [NN*WV-1:0]         oData_BM_Delta0,
    input  logic                     iValid_AM_Accum2,
    output logic                     oReady_AM_Accum2,
    input  logic [NC*WA-1:0]         iData_AM_Accum2,
    output logic [NR-1:0]            oValid_BM_Accum2,
    input  logic [NR-1:0]            iReady_BM_Accum2,
    output logic [NC*WA-1:0]         oData_BM_Accum2,
    output logic                     oOverrun
);

    localparam int WW = NC * NN * WV;
    localparam int DW = NN * WV;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_next;
    logic          w_sent, w_sent_next;
    logic          d_sent, d_sent_next;
    logic [WT-1:0] ptr, ptr_next;
    logic [WT-1:0] g, g_next;
    logic [WT-1:0] pick;
    logic          found;
    logic          w_hs, d_hs, done;
    logic          push, pop;
    logic [CW-1:0] cnt;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [WT-1:0] tag_mem [DEPTH];
    logic [WT-1:0] head;
    logic          overrun;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First pending request at or after the round-robin pointer, wrapping cyclically.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (!found && iValid_AM_Req[(int'(ptr) + i) % NR]) begin
                found = 1'b1;
                pick  = WT'((int'(ptr) + i) % NR);
            end
        end
    end

    always_comb begin
        state_next       = state;
        w_sent_next      = w_sent;
        d_sent_next      = d_sent;
        g_next           = g;
        ptr_next         = ptr;
        oValid_BM_Weight = 1'b0;
        oValid_BM_Delta0 = 1'b0;
        oReady_AM_Req    = '0;
        w_hs             = 1'b0;
        d_hs             = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (cnt < CW'(DEPTH) && found) begin
                    g_next      = pick;
                    w_sent_next = 1'b0;
                    d_sent_next = 1'b0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                oValid_BM_Weight = !w_sent;
                oValid_BM_Delta0 = !d_sent;
                w_hs             = oValid_BM_Weight & iReady_BM_Weight;
                d_hs             = oValid_BM_Delta0 & iReady_BM_Delta0;
                w_sent_next      = w_sent | w_hs;
                d_sent_next      = d_sent | d_hs;
                done             = w_sent_next & d_sent_next;
                if (done) begin
                    oReady_AM_Req[g] = 1'b1;
                    ptr_next         = (g == WT'(NR - 1)) ? '0 : g + 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign oData_BM_Weight = iData_AM_Weight[int'(g) * WW +: WW];
    assign oData_BM_Delta0 = iData_AM_Delta0[int'(g) * DW +: DW];

    // Results are routed by the oldest outstanding tag; nothing is accepted with no tag.
    assign head             = tag_mem[rd_ptr];
    assign oReady_AM_Accum2 = (cnt != '0) & iReady_BM_Accum2[head];
    assign oData_BM_Accum2  = iData_AM_Accum2;
    assign push             = done;
    assign pop              = iValid_AM_Accum2 & oReady_AM_Accum2;
    assign oOverrun         = overrun;

    always_comb begin
        oValid_BM_Accum2 = '0;
        if (iValid_AM_Accum2 && cnt != '0)
            oValid_BM_Accum2[head] = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (push)
            tag_mem[wr_ptr] <= g;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            w_sent  <= 1'b0;
            d_sent  <= 1'b0;
            ptr     <= '0;
            g       <= '0;
            cnt     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_next;
            w_sent <= w_sent_next;
            d_sent <= d_sent_next;
            ptr    <= ptr_next;
            g      <= g_next;
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
            if (iValid_AM_Accum2 && cnt == '0)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_backward_maccum_arbiter.sv
// Randomized bench for backward_maccum_arbiter, checked every cycle against a
// transaction-level model (pending grant plus a queue of outstanding tags).
module tb_backward_maccum_arbiter;

    localparam int NR    = 3;
    localparam int NN    = 7;
    localparam int NC    = 11;
    localparam int WV    = 5;
    localparam int DEPTH = 2;
    localparam int WA    = $clog2(NN) + WV;
    localparam int WW    = NC * NN * WV;
    localparam int DW    = NN * WV;
    localparam int AW    = NC * WA;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_ready;
    logic [NR*WW-1:0]  wt;
    logic [NR*DW-1:0]  dl;
    logic              w_valid, w_ready;
    logic [WW-1:0]     w_out;
    logic              d_valid, d_ready;
    logic [DW-1:0]     d_out;
    logic              acc_valid, acc_ready;
    logic [AW-1:0]     acc_data;
    logic [NR-1:0]     res_valid, res_ready;
    logic [AW-1:0]     res_data;
    logic              ovr;

    always #5 clk = ~clk;

    backward_maccum_arbiter #(
        .NR(NR), .NN(NN), .NC(NC), .WV(WV), .DEPTH(DEPTH)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .iValid_AM_Req(req),
        .oReady_AM_Req(req_ready),
        .iData_AM_Weight(wt),
        .iData_AM_Delta0(dl),
        .oValid_BM_Weight(w_valid),
        .iReady_BM_Weight(w_ready),
        .oData_BM_Weight(w_out),
        .oValid_BM_Delta0(d_valid),
        .iReady_BM_Delta0(d_ready),
        .oData_BM_Delta0(d_out),
        .iValid_AM_Accum2(acc_valid),
        .oReady_AM_Accum2(acc_ready),
        .iData_AM_Accum2(acc_data),
        .oValid_BM_Accum2(res_valid),
        .iReady_BM_Accum2(res_ready),
        .oData_BM_Accum2(res_data),
        .oOverrun(ovr)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit            m_valid   = 1'b0;
    bit            m_busy    = 1'b0;
    bit            m_wdone   = 1'b0;
    bit            m_ddone   = 1'b0;
    bit            m_overrun = 1'b0;
    int            m_g       = 0;
    int            m_ptr     = 0;
    int            m_tags[$];
    logic [NR-1:0] accepted  = '0;

    // stimulus knobs, percentages
    int p_req, p_rw, p_rd, p_vacc, p_racc, p_rst;
    bit force_rst = 1'b0;

    task automatic set_knobs(input int rq, input int rw, input int rd,
                             input int va, input int ra, input int rs);
        p_req  = rq;
        p_rw   = rw;
        p_rd   = rd;
        p_vacc = va;
        p_racc = ra;
        p_rst  = rs;
    endtask

    task automatic check_output(input string tag, input logic [511:0] obs,
                                input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    // Requesters hold valid and data steady until accepted, then may raise a fresh request.
    task automatic apply_stimulus();
        for (int r = 0; r < NR; r++) begin
            if (accepted[r])
                req[r] = 1'b0;
            if (!req[r] && $urandom_range(99) < p_req) begin
                req[r] = 1'b1;
                for (int b = 0; b < WW; b++)
                    wt[r*WW + b] = 1'($urandom_range(1));
                for (int b = 0; b < DW; b++)
                    dl[r*DW + b] = 1'($urandom_range(1));
            end
        end
        w_ready   = ($urandom_range(99) < p_rw);
        d_ready   = ($urandom_range(99) < p_rd);
        acc_valid = ($urandom_range(99) < p_vacc);
        for (int r = 0; r < NR; r++)
            res_ready[r] = ($urandom_range(99) < p_racc);
        for (int b = 0; b < AW; b++)
            acc_data[b] = 1'($urandom_range(1));
        rst = force_rst || ($urandom_range(99) < p_rst);
    endtask

    task automatic run_cycle();
        bit            vw, vd, whs, dhs, done, exp_racc;
        logic [NR-1:0] exp_rq, exp_vacc;
        int            size0;
        @(negedge clk);
        apply_stimulus();
        #1;
        size0    = m_tags.size();
        vw       = m_busy && !m_wdone;
        vd       = m_busy && !m_ddone;
        whs      = vw && w_ready;
        dhs      = vd && d_ready;
        done     = m_busy && (m_wdone || whs) && (m_ddone || dhs);
        exp_rq   = '0;
        if (done)
            exp_rq[m_g] = 1'b1;
        exp_racc = (size0 != 0) && res_ready[m_tags[0]];
        exp_vacc = '0;
        if (acc_valid && size0 != 0)
            exp_vacc[m_tags[0]] = 1'b1;
        if (m_valid) begin
            check_output("req_ready",  512'(req_ready), 512'(exp_rq));
            check_output("w_valid",    512'(w_valid),   512'(vw));
            check_output("d_valid",    512'(d_valid),   512'(vd));
            check_output("w_data",     512'(w_out),     512'(wt[m_g*WW +: WW]));
            check_output("d_data",     512'(d_out),     512'(dl[m_g*DW +: DW]));
            check_output("res_valid",  512'(res_valid), 512'(exp_vacc));
            check_output("acc_ready",  512'(acc_ready), 512'(exp_racc));
            check_output("res_data",   512'(res_data),  512'(acc_data));
            check_output("overrun",    512'(ovr),       512'(m_overrun));
        end
        @(posedge clk);
        if (rst) begin
            m_valid   = 1'b1;
            m_busy    = 1'b0;
            m_wdone   = 1'b0;
            m_ddone   = 1'b0;
            m_g       = 0;
            m_ptr     = 0;
            m_overrun = 1'b0;
            m_tags.delete();
            accepted  = '0;
        end else if (m_valid) begin
            if (acc_valid && size0 == 0)
                m_overrun = 1'b1;
            if (acc_valid && exp_racc)
                void'(m_tags.pop_front());
            accepted = exp_rq;
            if (done) begin
                m_tags.push_back(m_g);
                m_ptr  = (m_g + 1) % NR;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_wdone = m_wdone | whs;
                m_ddone = m_ddone | dhs;
            end else if (size0 < DEPTH && req != '0) begin
                for (int k = NR - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % NR])
                        m_g = (m_ptr + k) % NR;
                m_busy  = 1'b1;
                m_wdone = 1'b0;
                m_ddone = 1'b0;
            end
        end
    endtask

    task automatic reset_cycles(input int n);
        force_rst = 1'b1;
        repeat (n) run_cycle();
        force_rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        wt        = '0;
        dl        = '0;
        w_ready   = 1'b0;
        d_ready   = 1'b0;
        acc_valid = 1'b0;
        res_ready = '0;
        acc_data  = '0;

        set_knobs(0, 0, 0, 0, 0, 0);
        reset_cycles(2);

        // all requesters busy, unit always ready: back-to-back round robin
        set_knobs(100, 100, 100, 100, 100, 0);
        repeat (14) run_cycle();

        // results withheld until the tag FIFO is full, then drained
        reset_cycles(1);
        set_knobs(100, 100, 100, 0, 100, 0);
        repeat (10) run_cycle();
        set_knobs(100, 100, 100, 100, 100, 0);
        repeat (8) run_cycle();

        // weight accepted but delta stalled, then reset mid-grant
        reset_cycles(1);
        set_knobs(100, 100, 0, 0, 0, 0);
        repeat (3) run_cycle();
        reset_cycles(1);
        set_knobs(100, 100, 100, 100, 100, 0);
        repeat (8) run_cycle();

        // result with nothing outstanding, overrun must stick
        reset_cycles(1);
        set_knobs(0, 100, 100, 100, 100, 0);
        repeat (3) run_cycle();
        set_knobs(60, 50, 50, 50, 60, 0);
        repeat (200) run_cycle();

        // mixed handshakes with partial result readiness
        reset_cycles(1);
        set_knobs(70, 30, 30, 40, 50, 0);
        repeat (300) run_cycle();

        // fully random including occasional reset
        set_knobs(50, 50, 50, 50, 60, 2);
        repeat (1500) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
